uart_rx_oversample: RTL and testbench

// - UART receiver; the consumer of the baud generator's BAUD_TICK_X32 strobe (32 ticks per bit).
// - Samples RXD with 2-FF sync + 3-sample majority vote; frames start/data/[parity]/stop, LSB first.
// - Presents each received byte on a one-entry valid/ready output; reports framing and overrun errors.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_oversample.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and oversampling constants for rx and tx.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} uart_rx_state_t;
  localparam int OVS        = 32;
  localparam int SAMPLE_LO  = 15;
  localparam int SAMPLE_MID = 16;
  localparam int SAMPLE_HI  = 17;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: RXD metastability chain with falling-edge detect, idles high.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic rxd_i,
  output logic rxd_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  assign rxd_o  = sync_q[SYNC_STAGES-1];
  assign fall_o = prev_q & ~rxd_o;
endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: x32 oversampling UART receiver with one-entry valid/ready output.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 BAUD_TICK_X32,
  input  logic                 EN,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 FRAME_ERR,
`ifdef UART_RX_PARITY_EN
  input  logic                 PARITY_ODD,
  output logic                 PARITY_ERR,
`endif
  output logic                 OVERRUN
);
  uart_rx_state_t       state_q, state_d;
  logic [4:0]           tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 rxd_s, fall, maj, commit, wrap, load, take;
`ifdef UART_RX_PARITY_EN
  logic                 pbad_q, pbad_d, perr_q, perr_d;
`endif

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK   (CLK),
    .RST   (RST),
    .rxd_i (RXD),
    .rxd_o (rxd_s),
    .fall_o(fall)
  );

  assign commit = BAUD_TICK_X32 && tick_q == 5'(SAMPLE_HI);
  assign wrap   = BAUD_TICK_X32 && tick_q == 5'(OVS - 1);
  assign smp_d  = {(BAUD_TICK_X32 && tick_q == 5'(SAMPLE_MID)) ? rxd_s : smp_q[1],
                   (BAUD_TICK_X32 && tick_q == 5'(SAMPLE_LO))  ? rxd_s : smp_q[0]};
  // Third vote is the live synced sample taken on the commit tick itself.
  assign maj    = (smp_q[0] & smp_q[1]) | (rxd_s & (smp_q[0] | smp_q[1]));

  always_comb begin
    state_d = state_q;
    tick_d  = BAUD_TICK_X32 ? tick_q + 5'd1 : tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    load    = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE:
        if (fall) begin
          state_d = START;
          tick_d  = '0;
`ifdef UART_RX_PARITY_EN
          pbad_d  = 1'b0;
`endif
        end
      START:
        if (commit && maj) state_d = IDLE;
        else if (wrap) begin
          state_d = DATA;
          bit_d   = '0;
        end
      DATA: begin
        if (commit) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (wrap) bit_d = bit_q + 4'd1;
        if (wrap && bit_q == 4'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (commit) begin
          perr_d = maj != (^shift_q ^ PARITY_ODD);
          pbad_d = perr_d;
        end
        if (wrap) state_d = STOP;
      end
`endif
      STOP:
        if (commit) begin
          state_d = maj ? IDLE : WAIT_IDLE;
          ferr_d  = ~maj;
`ifdef UART_RX_PARITY_EN
          load    = maj & ~pbad_q;
`else
          load    = maj;
`endif
        end
      WAIT_IDLE:
        if (rxd_s) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
    if (!EN) begin
      state_d = IDLE;
      ferr_d  = 1'b0;
      load    = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end
  end

  // A full, undrained holding register keeps the old byte and flags the loss.
  assign ovr_d   = load & valid_q & ~RX_READY;
  assign take    = load & ~ovr_d;
  assign valid_d = take | (valid_q & ~RX_READY);
  assign data_d  = take ? shift_q : data_q;

  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      smp_q   <= '1;
      shift_q <= '1;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      pbad_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      pbad_q <= pbad_d;
      perr_q <= perr_d;
    end
  assign PARITY_ERR = perr_q;
`endif

  assign RX_DATA   = data_q;
  assign RX_VALID  = valid_q;
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: directed frames against a scoreboard of expected bytes and flag pulses.
module tb_uart_rx_oversample;
  logic CLK = 0, RST = 0, BAUD_TICK_X32 = 0, EN = 0, RXD = 1, RX_READY = 1;
  logic [7:0] RX_DATA;
  logic RX_VALID, FRAME_ERR, OVERRUN;
`ifdef UART_RX_PARITY_EN
  logic PARITY_ODD = 0, PARITY_ERR;
`endif
  logic par_flip = 0;
  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int exp_fe = 0, exp_ovr = 0, exp_pe = 0;
  bit m_full = 0;
  int got_n = 0, g = 0;
  logic [7:0] last_byte = 0, d_prev = 0, e_b;
  logic v_prev = 0, acc_prev = 0;

  uart_rx_oversample dut (
    .CLK(CLK), .RST(RST), .BAUD_TICK_X32(BAUD_TICK_X32), .EN(EN), .RXD(RXD),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY), .FRAME_ERR(FRAME_ERR),
`ifdef UART_RX_PARITY_EN
    .PARITY_ODD(PARITY_ODD), .PARITY_ERR(PARITY_ERR),
`endif
    .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge CLK);
      BAUD_TICK_X32 = (ph == 0);
      ph = (ph + 1) % 4;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    RXD = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input bit glitch, input int en_drop);
    drive(0, 128);
    for (int i = 0; i < 8; i++) begin
      if (i == en_drop) EN = 0;
      if (glitch && i == 3) begin
        drive(d[i], 64);
        drive(!d[i], 1);
        drive(d[i], 63);
      end else drive(d[i], 128);
    end
`ifdef UART_RX_PARITY_EN
    drive(^d ^ PARITY_ODD ^ par_flip, 128);
`endif
    drive(stop, 128);
  endtask

  // Frame-level expectation: what a correct receiver must report for this frame.
  task automatic model(input logic [7:0] d, input logic stop);
    bit pe;
    pe = 0;
`ifdef UART_RX_PARITY_EN
    pe = par_flip;
`endif
    if (pe) exp_pe++;
    if (!stop) exp_fe++;
    else if (!pe) begin
      if (m_full && !RX_READY) exp_ovr++;
      else begin
        exp_q.push_back(d);
        m_full = !RX_READY;
      end
    end
  endtask

  task automatic settle(input string name);
    drive(1, 256);
    chk({name, " bytes left"}, exp_q.size(), 0);
    chk({name, " frame_err owed"}, exp_fe, 0);
    chk({name, " overrun owed"}, exp_ovr, 0);
    chk({name, " parity_err owed"}, exp_pe, 0);
  endtask

  always begin
    @(negedge CLK);
    #1;
    if (RST) begin
      if (RX_VALID && !v_prev) begin
        got_n++;
        last_byte = RX_DATA;
      end
      if (v_prev && RX_VALID && !acc_prev) begin
        n_chk++;
        if (RX_DATA !== d_prev) begin
          n_fail++;
          $display("FAIL hold: RX_DATA=%h required %h", RX_DATA, d_prev);
        end
      end
      if (RX_VALID && RX_READY) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL accept: byte %h delivered, none required", RX_DATA);
        end else begin
          e_b = exp_q.pop_front();
          if (RX_DATA !== e_b) begin
            n_fail++;
            $display("FAIL accept: RX_DATA=%h required %h", RX_DATA, e_b);
          end
        end
      end
      if (FRAME_ERR) begin
        n_chk++;
        if (exp_fe == 0) begin n_fail++; $display("FAIL frame_err: pulse=1 required 0"); end
        else exp_fe--;
      end
      if (OVERRUN) begin
        n_chk++;
        if (exp_ovr == 0) begin n_fail++; $display("FAIL overrun: pulse=1 required 0"); end
        else exp_ovr--;
      end
`ifdef UART_RX_PARITY_EN
      if (PARITY_ERR) begin
        n_chk++;
        if (exp_pe == 0) begin n_fail++; $display("FAIL parity_err: pulse=1 required 0"); end
        else exp_pe--;
      end
`endif
      v_prev   = RX_VALID;
      acc_prev = RX_VALID && RX_READY;
      d_prev   = RX_DATA;
    end else begin
      v_prev   = 0;
      acc_prev = 0;
    end
  end

  initial begin
    EN = 1;
    repeat (5) @(negedge CLK);
    chk("reset valid", RX_VALID, 0);
    chk("reset data", RX_DATA, 0);
    chk("reset frame_err", FRAME_ERR, 0);
    chk("reset overrun", OVERRUN, 0);
    RST = 1;
    drive(1, 200);

    g = got_n;
    model(8'hA5, 1);
    send(8'hA5, 1, 0, -1);
    chk("a5 count", got_n, g + 1);
    chk("a5 byte", last_byte, 8'hA5);
    chk("a5 pulse ended", RX_VALID, 0);
    settle("a5");

    g = got_n;
    drive(0, 40);
    drive(1, 300);
    chk("glitch count", got_n, g);
    settle("glitch");

    model(8'h3C, 0);
    send(8'h3C, 0, 0, -1);
    chk("3c valid", RX_VALID, 0);
    drive(0, 640);
    drive(1, 128);
    model(8'h55, 1);
    send(8'h55, 1, 0, -1);
    chk("55 byte", last_byte, 8'h55);
    settle("framing");

    RX_READY = 0;
    model(8'h11, 1);
    send(8'h11, 1, 0, -1);
    drive(1, 128);
    model(8'h22, 1);
    send(8'h22, 1, 0, -1);
    drive(1, 128);
    chk("ovr valid held", RX_VALID, 1);
    chk("ovr data kept", RX_DATA, 8'h11);
    chk("ovr pulse seen", exp_ovr, 0);
    RX_READY = 1;
    m_full = 0;
    drive(1, 10);
    chk("ovr drained", RX_VALID, 0);
    settle("overrun");

    model(8'h6B, 1);
    send(8'h6B, 1, 1, -1);
    chk("6b byte", last_byte, 8'h6B);
    settle("data glitch");

    g = got_n;
    send(8'h96, 1, 0, 4);
    drive(1, 128);
    EN = 1;
    drive(1, 128);
    chk("en drop count", got_n, g);
    model(8'hF0, 1);
    send(8'hF0, 1, 0, -1);
    chk("f0 byte", last_byte, 8'hF0);
    settle("en drop");

`ifdef UART_RX_PARITY_EN
    g = got_n;
    par_flip = 1;
    model(8'hF0, 1);
    send(8'hF0, 1, 0, -1);
    par_flip = 0;
    chk("parity count", got_n, g);
    chk("parity valid", RX_VALID, 0);
    settle("parity");
`endif

    RX_READY = 0;
    model(8'h5A, 1);
    send(8'h5A, 1, 0, -1);
    drive(1, 128);
    chk("5a held", RX_DATA, 8'h5A);
    drive(0, 128);
    drive(1, 64);
    RST = 0;
    #1;
    chk("rst valid", RX_VALID, 0);
    chk("rst data", RX_DATA, 0);
    exp_q.delete();
    m_full = 0;
    RX_READY = 1;
    drive(1, 300);
    RST = 1;
    settle("rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
